// File: rtl/increment_scheduler_if.sv
// rtl/increment_scheduler_if.sv - request/ack/read bundle for the increment scheduler
interface increment_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 5
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] clr;
  logic [SW-1:0]   rd_sel;
  logic [W-1:0]    rd_val;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] wrap;
  logic            busy;

  modport master (output req, clr, rd_sel, input rd_val, ack, wrap, busy);
  modport slave  (input req, clr, rd_sel, output rd_val, ack, wrap, busy);
endinterface

// File: rtl/increment_scheduler.sv
// rtl/increment_scheduler.sv - round-robin sharing of one increment unit across NREQ counters
module increment_scheduler #(
  parameter int NREQ  = 4,
  parameter int W     = 5,
  parameter int LIMIT = 31
) (
  input logic                 clk,
  input logic                 resetn,
  increment_scheduler_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   g_q, g_d;
  logic [W-1:0]    operand_q, operand_d;
  logic [W-1:0]    cnt_q [NREQ];
  logic [W-1:0]    cnt_d [NREQ];
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] wrap_q, wrap_d;

  logic [SW-1:0]   win;
  logic            found;
  int              idx;
  logic            at_limit;

  // First requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        win   = SW'(idx);
        found = 1'b1;
      end
    end
  end

  assign at_limit = (operand_q == W'(LIMIT));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    operand_d = operand_q;
    ack_d     = '0;
    wrap_d    = '0;
    for (int i = 0; i < NREQ; i++) cnt_d[i] = cnt_q[i];

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          g_d     = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        operand_d = cnt_q[g_q];
        state_d   = COMMIT;
      end
      COMMIT: begin
        cnt_d[g_q]  = at_limit ? '0 : operand_q + W'(1);
        ack_d[g_q]  = 1'b1;
        wrap_d[g_q] = at_limit & ~bus.clr[g_q];
        ptr_d       = (g_q == SW'(NREQ - 1)) ? '0 : g_q + SW'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides any commit landing on the same counter
    for (int i = 0; i < NREQ; i++) begin
      if (bus.clr[i]) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      operand_q <= '0;
      ack_q     <= '0;
      wrap_q    <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      operand_q <= operand_d;
      ack_q     <= ack_d;
      wrap_q    <= wrap_d;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.ack    = ack_q;
  assign bus.wrap   = wrap_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.rd_val = (int'(bus.rd_sel) < NREQ) ? cnt_q[bus.rd_sel] : '0;
endmodule

// File: tb/tb_increment_scheduler.sv
// tb/tb_increment_scheduler.sv - directed bench with per-cycle model comparison
module tb_increment_scheduler;
  localparam int NREQ  = 4;
  localparam int W     = 5;
  localparam int LIMIT = 31;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  increment_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();
  increment_scheduler #(.NREQ(NREQ), .W(W), .LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: an operation in flight needs two more edges (operand fetch, then commit)
  int              m_cnt [NREQ] = '{default: 0};
  int              m_ptr = 0, m_g = 0, m_op = 0, m_stage = 0;
  logic [NREQ-1:0] m_ack = '0, m_wrap = '0;

  // Observation logs filled by the compare process
  int seen_cnt [NREQ];
  int ack_log[$], ack_cyc[$], val_log[$], idle_cyc[$];
  int wrap_cnt [NREQ];
  int wrap_cyc, stray_wrap;

  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic check(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREQ; i++) m_cnt[i] <= 0;
      m_ptr <= 0; m_stage <= 0; m_ack <= '0; m_wrap <= '0;
    end else begin
      m_ack  <= '0;
      m_wrap <= '0;
      if (m_stage == 0) begin
        if (bus.req != 0) begin
          m_g     <= rr_pick(bus.req, m_ptr);
          m_stage <= 2;
        end
      end else if (m_stage == 2) begin
        m_op    <= m_cnt[m_g];
        m_stage <= 1;
      end else begin
        m_cnt[m_g] <= (m_op == LIMIT) ? 0 : (m_op + 1) % (1 << W);
        m_ack      <= NREQ'(1) << m_g;
        if (m_op == LIMIT && !bus.clr[m_g]) m_wrap <= NREQ'(1) << m_g;
        m_ptr      <= (m_g + 1) % NREQ;
        m_stage    <= 0;
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.clr[i]) m_cnt[i] <= 0;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("ack", bus.ack, m_ack);
      check("wrap", bus.wrap, m_wrap);
      check("busy", bus.busy, (m_stage != 0));
      for (int i = 0; i < NREQ; i++) begin
        bus.rd_sel = 2'(i);
        #1;
        check($sformatf("cnt%0d", i), bus.rd_val, m_cnt[i]);
        seen_cnt[i] = bus.rd_val;
      end
      if (!bus.busy) idle_cyc.push_back(cyc);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          ack_log.push_back(i);
          ack_cyc.push_back(cyc);
          val_log.push_back(seen_cnt[i]);
        end
        if (bus.wrap[i]) begin
          wrap_cnt[i]++;
          wrap_cyc = cyc;
          if (!bus.ack[i]) stray_wrap++;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_cyc.delete(); val_log.delete(); idle_cyc.delete();
    for (int i = 0; i < NREQ; i++) wrap_cnt[i] = 0;
    wrap_cyc = -1;
    stray_wrap = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  // Hold req[idx] for exactly n grants, releasing it in the last ack cycle
  task automatic bump(int idx, int n);
    bus.req[idx] = 1'b1;
    tick(3 * n);
    bus.req[idx] = 1'b0;
    tick(2);
  endtask

  initial begin : stim
    int s;
    int lows;
    bus.req = '0;
    bus.clr = '0;
    bus.rd_sel = '0;
    clear_logs();

    // 1: reset state, then four increments of counter 0
    tick(2);
    for (int i = 0; i < NREQ; i++) check($sformatf("reset_cnt%0d", i), seen_cnt[i], 0);
    check("reset_busy", bus.busy, 0);
    resetn = 1'b1;
    clear_logs();
    s = cyc + 1;
    bump(0, 4);
    check("t1_acks", ack_log.size(), 4);
    check("t1_vals", {8'(val_log[0]), 8'(val_log[1]), 8'(val_log[2]), 8'(val_log[3])}, 32'h01020304);
    check("t1_first_ack", ack_cyc[0] - s, 2);
    check("t1_spacing", {8'(ack_cyc[1] - ack_cyc[0]), 8'(ack_cyc[2] - ack_cyc[1]), 8'(ack_cyc[3] - ack_cyc[2])}, 32'h030303);
    check("t1_model_cnt0", m_cnt[0], 4);

    // 2: all requesters held from reset, eight grants
    resetn = 1'b0;
    bus.req = 4'b1111;
    tick(2);
    clear_logs();
    resetn = 1'b1;
    tick(24);
    bus.req = '0;
    tick(3);
    check("t2_acks", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) check($sformatf("t2_order%0d", i), ack_log[i], i % 4);
    for (int i = 0; i < NREQ; i++) check($sformatf("t2_cnt%0d", i), seen_cnt[i], 2);
    lows = 0;
    if (ack_cyc.size() == 8)
      foreach (idle_cyc[j]) if (idle_cyc[j] >= ack_cyc[0] && idle_cyc[j] <= ack_cyc[7]) lows++;
    check("t2_idle_gaps", lows, 8);

    // 3: wrap of counter 2 from LIMIT to 0
    do_reset();
    clear_logs();
    bump(2, 32);
    check("t3_acks", ack_log.size(), 32);
    if (val_log.size() == 32) begin
      check("t3_val30", val_log[29], 30);
      check("t3_val31", val_log[30], 31);
      check("t3_val0", val_log[31], 0);
      check("t3_wrap_with_ack", wrap_cyc, ack_cyc[31]);
    end
    check("t3_wrap2", wrap_cnt[2], 1);
    check("t3_wrap_other", wrap_cnt[0] + wrap_cnt[1] + wrap_cnt[3], 0);
    check("t3_stray", stray_wrap, 0);
    check("t3_model_cnt2", m_cnt[2], 0);

    // 4: clear during COMMIT, then clear during ISSUE
    do_reset();
    bump(1, 7);
    check("t4_pre", seen_cnt[1], 7);
    clear_logs();
    bus.req = 4'b0010; tick(1);
    bus.req = '0;      tick(1);
    bus.clr = 4'b0010; tick(1);
    bus.clr = '0;      tick(2);
    check("t4_commit_clr_cnt", seen_cnt[1], 0);
    check("t4_commit_clr_ack", ack_log.size(), 1);
    check("t4_commit_clr_wrap", wrap_cnt[1], 0);
    bump(1, 7);
    check("t4_pre2", seen_cnt[1], 7);
    clear_logs();
    bus.req = 4'b0010; tick(1);
    bus.req = '0;
    bus.clr = 4'b0010; tick(1);
    bus.clr = '0;      tick(3);
    check("t4_issue_clr_cnt", seen_cnt[1], 8);
    check("t4_issue_clr_ack", ack_log.size(), 1);

    // 5: reset during ISSUE aborts the increment and rewinds the pointer
    do_reset();
    bump(3, 5);
    check("t5_pre", seen_cnt[3], 5);
    clear_logs();
    bus.req = 4'b1000; tick(1);
    bus.req = '0;
    resetn = 1'b0;     tick(2);
    check("t5_cnt3", seen_cnt[3], 0);
    check("t5_no_ack", ack_log.size(), 0);
    resetn = 1'b1;
    bus.req = 4'b1001; tick(1);
    bus.req = '0;      tick(4);
    check("t5_acks", ack_log.size(), 1);
    if (ack_log.size() > 0) check("t5_first_grant", ack_log[0], 0);

    // 6: single-cycle request still commits exactly once
    do_reset();
    clear_logs();
    bus.req = 4'b0100; tick(1);
    bus.req = '0;      tick(6);
    check("t6_cnt2", seen_cnt[2], 1);
    check("t6_acks", ack_log.size(), 1);
    if (ack_log.size() > 0) check("t6_ack_idx", ack_log[0], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
